// File: rtl/counter_rr.sv
// counter_rr: free-running step counter used as the PC/step source.
// Optional build macro COUNTER_RR_SATURATE_EN holds at WRAP_VALUE instead of wrapping.
module counter_rr #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] STEP        = WIDTH'(4),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] WRAP_VALUE  = WIDTH'(32'hFFFF_FFFC)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    // Declaration initialiser gives a defined count at power-up, before any reset.
    logic [WIDTH-1:0] r_count = RESET_VALUE;
    logic [WIDTH-1:0] w_next;
    logic             w_atWrap;

    assign w_atWrap = (r_count == WRAP_VALUE);

    always_comb begin
        w_next = r_count + STEP;
        if (w_atWrap) begin
`ifdef COUNTER_RR_SATURATE_EN
            w_next = WRAP_VALUE;
`else
            w_next = RESET_VALUE;
`endif
        end
    end

    // Reset outranks both wrap/saturate and increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VALUE;
        end else begin
            r_count <= w_next;
        end
    end

    assign out = r_count;

endmodule

// File: tb/tb_counter_rr.sv
// tb_counter_rr: directed self-checking bench for counter_rr (default, WRAP=16 and 8-bit full-range builds).
// Expected sequences follow COUNTER_RR_SATURATE_EN when that macro is defined.
module tb_counter_rr;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] outDef;
    logic [31:0] out16;
    logic [7:0]  out8;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clock = ~clock;

    counter_rr dutDef (
        .clk   (clock),
        .reset (reset),
        .out   (outDef)
    );

    counter_rr #(
        .WIDTH      (32),
        .STEP       (32'd4),
        .RESET_VALUE(32'd0),
        .WRAP_VALUE (32'd16)
    ) dut16 (
        .clk   (clock),
        .reset (reset),
        .out   (out16)
    );

    counter_rr #(
        .WIDTH      (8),
        .STEP       (8'd1),
        .RESET_VALUE(8'd0),
        .WRAP_VALUE (8'hFF)
    ) dut8 (
        .clk   (clock),
        .reset (reset),
        .out   (out8)
    );

    // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
    task automatic tick();
        @(negedge clock);
    endtask

    // No reset from t=0: all instances start at RESET_VALUE and step immediately.
    task automatic test_powerup();
        logic [31:0] expDef [4];
        logic [7:0]  exp8   [4];
        expDef = '{32'd0, 32'd4, 32'd8, 32'd12};
        exp8   = '{8'd0, 8'd1, 8'd2, 8'd3};
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            nCompared++;
            if (outDef !== expDef[i]) begin
                nMismatched++;
                $display("[TB] FAIL powerup_def[%0d]: got %0d expected %0d", i, outDef, expDef[i]);
            end
            nCompared++;
            if (out16 !== expDef[i]) begin
                nMismatched++;
                $display("[TB] FAIL powerup_w16[%0d]: got %0d expected %0d", i, out16, expDef[i]);
            end
            nCompared++;
            if (out8 !== exp8[i]) begin
                nMismatched++;
                $display("[TB] FAIL powerup_w8[%0d]: got %0d expected %0d", i, out8, exp8[i]);
            end
        end
    endtask

    // Reset held across three edges keeps the count at 0; release steps 4 then 8.
    task automatic test_reset_hold();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++;
            if (outDef !== 32'd0) begin
                nMismatched++;
                $display("[TB] FAIL reset_hold[%0d]: got %0d expected 0", i, outDef);
            end
        end
        reset = 1'b0;
        tick();
        nCompared++;
        if (outDef !== 32'd4) begin
            nMismatched++;
            $display("[TB] FAIL reset_release1: got %0d expected 4", outDef);
        end
        tick();
        nCompared++;
        if (outDef !== 32'd8) begin
            nMismatched++;
            $display("[TB] FAIL reset_release2: got %0d expected 8", outDef);
        end
    endtask

    // Count to 40, then a single reset edge returns to 0 and counting restarts at 4.
    task automatic test_mid_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        nCompared++;
        if (outDef !== 32'd40) begin
            nMismatched++;
            $display("[TB] FAIL mid_count40: got %0d expected 40", outDef);
        end
        reset = 1'b1;
        tick();
        nCompared++;
        if (outDef !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: got %0d expected 0", outDef);
        end
        reset = 1'b0;
        tick();
        nCompared++;
        if (outDef !== 32'd4) begin
            nMismatched++;
            $display("[TB] FAIL mid_after: got %0d expected 4", outDef);
        end
    endtask

    // WRAP_VALUE=16: wraps to 0 by default, saturates at 16 when the macro is set.
    task automatic test_wrap16();
        logic [31:0] exp16 [7];
`ifdef COUNTER_RR_SATURATE_EN
        exp16 = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd16, 32'd16};
`else
        exp16 = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd0, 32'd4};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            nCompared++;
            if (out16 !== exp16[i]) begin
                nMismatched++;
                $display("[TB] FAIL wrap16[%0d]: got %0d expected %0d", i, out16, exp16[i]);
            end
        end
        reset = 1'b1;
        tick();
        nCompared++;
        if (out16 !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL wrap16_reset: got %0d expected 0", out16);
        end
        reset = 1'b0;
    endtask

    // 8-bit, STEP=1, WRAP=FF: 254, 255, then 0, 1 (or held at 255 when saturating).
    task automatic test_full_range();
        logic [7:0] exp8 [4];
`ifdef COUNTER_RR_SATURATE_EN
        exp8 = '{8'd254, 8'd255, 8'd255, 8'd255};
`else
        exp8 = '{8'd254, 8'd255, 8'd0, 8'd1};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            nCompared++;
            if (out8 !== exp8[i]) begin
                nMismatched++;
                $display("[TB] FAIL full_range[%0d]: got %0d expected %0d", i, out8, exp8[i]);
            end
        end
    endtask

    initial begin
        $display("[TB] counter_rr directed test start");
        test_powerup();
        test_reset_hold();
        test_mid_reset();
        test_wrap16();
        test_full_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
